// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and memory-busy freeze
// for the PC, IF/ID and ID/EX registers. Define HAZ_PERF_CNT_EN to add saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rs,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic [1:0]       state_o
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
  , output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_FREEZE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] cnt_q, cnt_d;
  logic            load_use;

  assign load_use = id_ex_memread && (id_ex_rt != '0) &&
                    ((if_id_uses_rs && (id_ex_rt == if_id_rs)) ||
                     (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = S_RUN;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          state_d     = S_FREEZE;
        end else if (branch_taken) begin
          // Branch beats a simultaneous load-use: the stalled instruction is wrong-path anyway.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = FC_LOAD;
            state_d = S_FLUSH;
          end
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      S_FLUSH: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          state_d     = S_FLUSH;
        end else begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - FC_W'(1);
          state_d      = (cnt_d == '0) ? S_RUN : S_FLUSH;
        end
      end
      S_FREEZE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        state_d     = mem_busy ? S_FREEZE : S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  // A bubble without a flush is a load-use stall; id_ex_write low only while held by memory.
  logic stall_ev, hold_ev;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  assign stall_ev = id_ex_bubble && !if_id_flush;
  assign hold_ev  = !id_ex_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1))     stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (if_id_flush && (flush_cnt_q != '1))  flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
      if (hold_ev && (freeze_cnt_q != '1))     freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, reset corner cases and a random run
// checked against an abstract pipeline model (flush cycles pending, frozen flag).
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int FC    = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_rt;
  logic             if_id_uses_rs, if_id_uses_rt, id_ex_memread, branch_taken, mem_busy;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic [1:0]       state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic             s_pc, s_ifw, s_fl, s_idw, s_bub;
  logic [1:0]       s_st;
  logic [1:0]       s_stall, s_flush, s_freeze;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .FLUSH_CYCLES(FC)
`ifdef HAZ_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .state_o(state_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

`ifdef HAZ_PERF_CNT_EN
  pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(s_pc), .if_id_write(s_ifw), .if_id_flush(s_fl),
    .id_ex_write(s_idw), .id_ex_bubble(s_bub), .state_o(s_st),
    .stall_cnt(s_stall), .flush_cnt(s_flush), .freeze_cnt(s_freeze)
  );
`endif

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] exrt;
    logic       br, busy;
    logic       pc, ifw, fl, idw, bub;
    logic [1:0] st;
  } vec_t;

  vec_t tab[23];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: pending wrong-path cycles and whether the pipe is frozen.
  int   m_flush_left, m_stalls, m_flushes, m_freezes;
  bit   m_frz;
  logic e_pc, e_ifw, e_fl, e_idw, e_bub;
  int   e_st;

  function automatic vec_t mk(int rs, int rt, int urs, int urt, int mr, int exrt, int br,
                              int busy, int pc, int ifw, int fl, int idw, int bub, int st);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt); v.mr = 1'(mr);
    v.exrt = 5'(exrt); v.br = 1'(br); v.busy = 1'(busy);
    v.pc = 1'(pc); v.ifw = 1'(ifw); v.fl = 1'(fl); v.idw = 1'(idw); v.bub = 1'(bub);
    v.st = 2'(st);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    if_id_rs = v.rs; if_id_rt = v.rt; if_id_uses_rs = v.urs; if_id_uses_rt = v.urt;
    id_ex_memread = v.mr; id_ex_rt = v.exrt; branch_taken = v.br; mem_busy = v.busy;
  endtask

  function automatic bit hazard();
    if (!id_ex_memread || id_ex_rt == 0) return 0;
    return (if_id_uses_rs && id_ex_rt == if_id_rs) || (if_id_uses_rt && id_ex_rt == if_id_rt);
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_frz = 0; m_stalls = 0; m_flushes = 0; m_freezes = 0;
  endtask

  task automatic model_out();
    if (!rst_n)                               {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00111;
    else if (m_frz || mem_busy)               {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00000;
    else if (m_flush_left > 0 || branch_taken) {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b11111;
    else if (hazard())                        {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b00011;
    else                                      {e_pc, e_ifw, e_fl, e_idw, e_bub} = 5'b11010;
    e_st = (!rst_n) ? 0 : m_frz ? 2 : (m_flush_left > 0) ? 1 : 0;
  endtask

  task automatic model_clock();
    if (!rst_n) model_reset();
    else if (m_frz) begin m_freezes++; m_frz = mem_busy; end
    else if (mem_busy) begin m_freezes++; if (m_flush_left == 0) m_frz = 1; end
    else if (m_flush_left > 0) begin m_flushes++; m_flush_left--; end
    else if (branch_taken) begin m_flushes++; m_flush_left = FC - 1; end
    else if (hazard()) m_stalls++;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_stalls));
    chk({tag, " flush_cnt"}, 64'(flush_cnt), 64'(m_flushes));
    chk({tag, " freeze_cnt"}, 64'(freeze_cnt), 64'(m_freezes));
    chk({tag, " sat stall_cnt"}, 64'(s_stall), 64'((m_stalls > 3) ? 3 : m_stalls));
    chk({tag, " sat flush_cnt"}, 64'(s_flush), 64'((m_flushes > 3) ? 3 : m_flushes));
    chk({tag, " sat freeze_cnt"}, 64'(s_freeze), 64'((m_freezes > 3) ? 3 : m_freezes));
`else
    if (tag.len() < 0) chk(tag, 0, 1);
`endif
  endtask

  task automatic chk_model(input string tag);
    model_out();
    chk({tag, " pc_write"}, 64'(pc_write), 64'(e_pc));
    chk({tag, " if_id_write"}, 64'(if_id_write), 64'(e_ifw));
    chk({tag, " if_id_flush"}, 64'(if_id_flush), 64'(e_fl));
    chk({tag, " id_ex_write"}, 64'(id_ex_write), 64'(e_idw));
    chk({tag, " id_ex_bubble"}, 64'(id_ex_bubble), 64'(e_bub));
    chk({tag, " state_o"}, 64'(state_o), 64'(e_st));
    chk_cnt(tag);
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, " pc_write"}, 64'(pc_write), 64'(v.pc));
    chk({tag, " if_id_write"}, 64'(if_id_write), 64'(v.ifw));
    chk({tag, " if_id_flush"}, 64'(if_id_flush), 64'(v.fl));
    chk({tag, " id_ex_write"}, 64'(id_ex_write), 64'(v.idw));
    chk({tag, " id_ex_bubble"}, 64'(id_ex_bubble), 64'(v.bub));
    chk({tag, " state_o"}, 64'(state_o), 64'(v.st));
  endtask

  initial begin
    vec_t idle, v;
    idle = mk(0,0,0,0,0,0,0,0, 1,1,0,1,0,0);
    //          rs rt urs urt mr exrt br busy | pc ifw fl idw bub st
    tab[0]  = idle;
    tab[1]  = mk(8, 0, 1, 0, 1, 8, 0, 0,  0, 0, 0, 1, 1, 0);
    tab[2]  = mk(8, 0, 1, 0, 0, 8, 0, 0,  1, 1, 0, 1, 0, 0);
    tab[3]  = mk(0, 0, 1, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0);
    tab[4]  = mk(0, 9, 0, 1, 1, 9, 0, 0,  0, 0, 0, 1, 1, 0);
    tab[5]  = mk(0, 9, 0, 0, 1, 9, 0, 0,  1, 1, 0, 1, 0, 0);
    tab[6]  = mk(8, 0, 1, 0, 1, 8, 1, 0,  1, 1, 1, 1, 1, 0);
    tab[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 1, 1, 1);
    tab[8]  = idle;
    tab[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 1, 1, 0);
    tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    tab[11] = tab[10];
    tab[12] = tab[10];
    tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 1, 1);
    tab[14] = idle;
    tab[15] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2);
    tab[17] = mk(8, 0, 1, 0, 1, 8, 0, 0,  0, 0, 0, 0, 0, 2);
    tab[18] = mk(8, 0, 1, 0, 1, 8, 0, 0,  0, 0, 0, 1, 1, 0);
    tab[19] = idle;
    tab[20] = mk(0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
    tab[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2);
    tab[22] = idle;

    // Power-on reset
    rst_n = 1'b0;
    drive(idle);
    model_reset();
    #1;
    chk_vec("por", mk(0,0,0,0,0,0,0,0, 0,0,1,1,1,0));
    chk_cnt("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 23; i++) begin
      drive(tab[i]);
      #1;
      chk_vec($sformatf("vec%0d", i), tab[i]);
      chk_cnt($sformatf("vec%0d", i));
      model_clock();
      @(negedge clk);
    end

    // Reset asserted mid-flush: outputs take reset values at once, then run resumes
    v = idle; v.br = 1'b1;
    drive(v); #1; chk_model("pre-rst flush"); model_clock();
    @(negedge clk);
    drive(idle); #1; chk_model("in flush");
    #2 rst_n = 1'b0; #1;
    model_reset();
    chk_vec("rst mid-flush", mk(0,0,0,0,0,0,0,0, 0,0,1,1,1,0));
    chk_cnt("rst mid-flush");
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk_vec("post-rst run", idle);

    // Reset asserted mid-freeze
    @(negedge clk);
    v = idle; v.busy = 1'b1;
    drive(v); #1; chk_model("pre-rst freeze"); model_clock();
    @(negedge clk);
    #1; chk_model("in freeze");
    #2 rst_n = 1'b0; #1;
    model_reset();
    chk("rst mid-freeze state_o", 64'(state_o), 64'(0));
    chk("rst mid-freeze pc_write", 64'(pc_write), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle); #1;
    chk_model("post-rst freeze");
    model_clock();
    @(negedge clk);

    // Random run against the model
    for (int c = 0; c < 600; c++) begin
      if_id_rs      = 5'($urandom_range(0, 3));
      if_id_rt      = 5'($urandom_range(0, 3));
      id_ex_rt      = 5'($urandom_range(0, 3));
      if_id_uses_rs = 1'($urandom_range(0, 1));
      if_id_uses_rt = 1'($urandom_range(0, 1));
      id_ex_memread = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 7) == 0);
      mem_busy      = ($urandom_range(0, 5) == 0);
      #1;
      chk_model($sformatf("rnd%0d", c));
      model_clock();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
